ft_recovery_loader: RTL and testbench
=====================================

Name: ft_recovery_loader

Overview:
- Sits directly downstream of the fault-tolerance module, behind its recovery control outputs and its safe-memory data port.
- When recovery is requested, reads every checkpointed GPR and the saved PC out of the safe memory, one word at a time, over the req/gnt/rvalid interface.
- Replays the GPRs into the cores' register-file write ports, presents the PC for loading, then pulses the done signal consumed upstream as recovery-done.

Parameters:
- DATA_WIDTH, 32, width of GPR and PC words.
- ADDR_WIDTH, 5, GPR index width.
- NUM_REGS, 32, number of GPRs; x0 is never restored.
- BASE_ADDR, 32'h0000_0000, safe-memory byte address of GPR 0.
- TIMEOUT_CYCLES, 64, watchdog limit; used only under FT_LOADER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- recover_i  in  1  recovery request (level) from the control FSM.
- data_req_o  out  1  safe-memory read request.
- data_gnt_i  in  1  request accepted.
- data_rvalid_i  in  1  read data valid.
- data_addr_o  out  32  byte address of the requested word.
- data_rdata_i  in  DATA_WIDTH  read data.
- data_err_i  in  1  read error, qualified by rvalid.
- rf_we_o  out  1  GPR write strobe to both cores.
- rf_waddr_o  out  ADDR_WIDTH  GPR index.
- rf_wdata_o  out  DATA_WIDTH  GPR value.
- pc_o  out  DATA_WIDTH  restored PC.
- pc_valid_o  out  1  one-cycle PC load strobe.
- done_o  out  1  one-cycle recovery-complete pulse.
- busy_o  out  1  sequence in progress.
- error_o  out  1  sticky fault during restore.

Behaviour:
- Reset:
  - All outputs are 0.
  - The FSM is in IDLE and the index is 1.
- Memory map:
  - GPR i is at BASE_ADDR+4*i.
  - The PC is at BASE_ADDR+4*NUM_REGS.
- States: IDLE, REQ, WAIT, DONE, ERROR.
- IDLE:
  - A rising edge of recover_i (0 in the previous cycle, 1 now) moves to REQ with idx=1.
  - A recover_i held high after a completed or errored sequence does not restart.
- REQ:
  - data_req_o=1 and data_addr_o=BASE_ADDR+4*idx, both held stable until gnt.
  - On data_gnt_i: go to WAIT, and data_req_o drops in the next cycle.
- WAIT:
  - data_req_o=0; at most one outstanding request.
  - On data_rvalid_i with data_err_i=1: go to ERROR.
  - On data_rvalid_i, data_err_i=0, idx<NUM_REGS: next cycle rf_we_o=1 for exactly one cycle, with rf_waddr_o=idx[ADDR_WIDTH-1:0] and rf_wdata_o=captured data. idx increments and the state returns to REQ in the same cycle; the write strobe overlaps the next request.
  - On data_rvalid_i, data_err_i=0, idx==NUM_REGS: next cycle pc_o=data and pc_valid_o=1 for one cycle, and the state goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- ERROR:
  - error_o=1 and done_o is never asserted.
  - Leaves to IDLE only when recover_i=0; error_o clears on leaving.
- busy_o=1 in REQ, WAIT and DONE.
- rf_waddr_o and rf_wdata_o hold their last values when rf_we_o=0. pc_o holds its value.
- Latency: with gnt in the REQ cycle and rvalid one cycle later, each word takes 2 cycles. For NUM_REGS=32 (31 GPRs + PC), done_o rises 65 cycles after the recover_i edge.
- recover_i falling mid-sequence: ignored, the sequence completes.
- rvalid without an outstanding request (IDLE or REQ): ignored.
- rst_ni asserted mid-sequence: immediate return to IDLE with all outputs 0 and no pending request tracked. A late rvalid after reset is ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
- FT_LOADER_TIMEOUT_EN defined:
  - A counter runs in REQ and WAIT and reloads on every state change.
  - If it reaches TIMEOUT_CYCLES without gnt (in REQ) or rvalid (in WAIT), the FSM enters ERROR: data_req_o drops and error_o=1.
- Undefined: no counter, and the block waits indefinitely.

Test Plan:
- Memory preloaded with word i = 32'hA000_0000+i and PC 32'h0000_0180; gnt immediate, rvalid +1 cycle; pulse recover_i → 31 rf_we_o strobes, idx 1..31 with matching data; pc_o=32'h180 with pc_valid_o one cycle; done_o exactly 65 cycles after the edge.
- gnt delayed 3 cycles on idx 5 → data_addr_o=BASE+20 and data_req_o stable for 4 cycles; order and data unchanged; done_o 68 cycles after the edge.
- data_err_i with rvalid on idx 10 → rf_we_o count stops at 9; error_o=1, done_o never asserts; recover_i=0 → IDLE and error_o=0.
- recover_i held high through a completed sequence → exactly one done_o pulse and no restart; a fresh 0→1 edge → a second full sequence.
- rst_ni low while in WAIT on idx 7, rvalid arrives during reset → all outputs 0 and no rf_we_o; after release, a new recover_i edge restarts at idx 1.
- With FT_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted → error_o=1 and data_req_o=0 after 8 cycles in REQ; without the macro, data_req_o stays 1 indefinitely.

Source files
------------

// File: rtl/ft_recovery_loader_if.sv
// Safe-memory read port between the recovery loader (master) and the
// fault-tolerance module's checkpoint memory (slave): req/gnt/rvalid handshake.
interface ft_recovery_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic                  data_rvalid_i;
    logic [31:0]           data_addr_o;
    logic [DATA_WIDTH-1:0] data_rdata_i;
    logic                  data_err_i;

    modport master (
        output data_req_o,
        output data_addr_o,
        input  data_gnt_i,
        input  data_rvalid_i,
        input  data_rdata_i,
        input  data_err_i
    );

    modport slave (
        input  data_req_o,
        input  data_addr_o,
        output data_gnt_i,
        output data_rvalid_i,
        output data_rdata_i,
        output data_err_i
    );
endinterface

// File: rtl/ft_recovery_loader.sv
// ft_recovery_loader: on a rising edge of recover_i, reads GPRs 1..NUM_REGS-1
// and then the saved PC out of safe memory (one outstanding read at a time),
// replays the GPRs on the register-file write port, strobes the PC and pulses
// done_o. A read error parks the block in ERROR until recover_i drops.
// Optional watchdog on stalled gnt/rvalid: define FT_LOADER_TIMEOUT_EN.
module ft_recovery_loader #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 5,
    parameter int          NUM_REGS       = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    recover_i,
    ft_recovery_loader_if.master    mem,
    output logic                    rf_we_o,
    output logic [ADDR_WIDTH-1:0]   rf_waddr_o,
    output logic [DATA_WIDTH-1:0]   rf_wdata_o,
    output logic [DATA_WIDTH-1:0]   pc_o,
    output logic                    pc_valid_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic                    error_o
);

    // Index runs 1..NUM_REGS; index NUM_REGS is the PC word.
    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_e;

    // Byte address of checkpoint word idx; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
        word_addr = BASE_ADDR + (32'(idx) << 32'd2);
    endfunction

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   recover_prev_q;
    logic                   tmo_expired_s;

    logic                   req_q, req_d;
    logic [31:0]            addr_q, addr_d;
    logic                   rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic [DATA_WIDTH-1:0]  pc_q, pc_d;
    logic                   pc_valid_q, pc_valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;

`ifdef FT_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Watchdog count: advances while waiting in REQ/WAIT, reloads on any state change
    always_comb begin
        tmo_d = {TMO_W{1'b0}};
        if (state_d != state_q) begin
            tmo_d = {TMO_W{1'b0}};
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_expired_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expired_s = 1'b0;
`endif

    // State, word index and recover_i edge-detect registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            idx_q          <= IDX_FIRST;
            recover_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            recover_prev_q <= recover_i;
        end
    end

    // Next-state and index sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                // Only a fresh 0->1 edge starts a sequence; a held level does not.
                if (recover_i && !recover_prev_q) begin
                    state_d = S_REQ;
                    idx_d   = IDX_FIRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem.data_gnt_i) begin
                    state_d = S_WAIT;
                end else if (tmo_expired_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem.data_rvalid_i) begin
                    if (mem.data_err_i) begin
                        state_d = S_ERROR;
                    end else if (idx_q < IDX_LAST) begin
                        state_d = S_REQ;
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tmo_expired_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = IDX_FIRST;
            end
            S_ERROR: begin
                if (!recover_i) begin
                    state_d = S_IDLE;
                    idx_d   = IDX_FIRST;
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = IDX_FIRST;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state transition
    always_comb begin
        req_d      = (state_d == S_REQ);
        addr_d     = addr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pc_d       = pc_q;
        pc_valid_d = 1'b0;
        done_d     = (state_q == S_DONE);
        busy_d     = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);

        if (state_d == S_REQ) begin
            addr_d = word_addr(idx_d);
        end else begin
            addr_d = addr_q;
        end

        // A good response either becomes a GPR write or, for the last word, the PC.
        if ((state_q == S_WAIT) && mem.data_rvalid_i && !mem.data_err_i) begin
            if (idx_q < IDX_LAST) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = ADDR_WIDTH'(idx_q);
                rf_wdata_d = mem.data_rdata_i;
            end else begin
                pc_d       = mem.data_rdata_i;
                pc_valid_d = 1'b1;
            end
        end else begin
            rf_we_d    = 1'b0;
            pc_valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_WIDTH{1'b0}};
            rf_wdata_q <= {DATA_WIDTH{1'b0}};
            pc_q       <= {DATA_WIDTH{1'b0}};
            pc_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign mem.data_req_o  = req_q;
    assign mem.data_addr_o = addr_q;
    assign rf_we_o         = rf_we_q;
    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_ft_recovery_loader.sv
// Bench for ft_recovery_loader: a behavioural safe-memory responder with
// per-word grant stalls and error injection, a monitor logging every
// register-file write / PC strobe / done pulse, and a reference model that
// derives the expected write list, PC and done latency from the memory image.
module tb_ft_recovery_loader;
    localparam int          DW   = 32;
    localparam int          AW   = 5;
    localparam int          NR   = 32;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          recover_i = 1'b0;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [DW-1:0] pc_o;
    logic          pc_valid_o, done_o, busy_o, error_o;

    ft_recovery_loader_if #(.DATA_WIDTH(DW)) mem_if ();

    ft_recovery_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .recover_i(recover_i), .mem(mem_if),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .done_o(done_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory image and responder controls
    logic [DW-1:0] memw [0:NR];
    int  gdel [0:NR];
    int  err_idx = 0;
    bit  gnt_block = 1'b0;
    bit  spur = 1'b0;

    // Monitor logs
    int            wr_idx_q [$];
    logic [DW-1:0] wr_dat_q [$];
    int  req_cnt [0:NR];
    int  pc_cnt, done_cnt, pc_cyc, done_cyc;
    logic [DW-1:0] pc_seen;
    int  cyc = 0;
    int  t_edge = 0;

    int  n_checks = 0;
    int  n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Safe-memory responder: grant after gdel[idx] stall cycles, data one cycle later
    initial begin
        bit pend;
        int pend_idx, stall, cur;
        pend = 1'b0; pend_idx = 0; stall = 0;
        mem_if.data_gnt_i    = 1'b0;
        mem_if.data_rvalid_i = 1'b0;
        mem_if.data_rdata_i  = '0;
        mem_if.data_err_i    = 1'b0;
        forever begin
            @(negedge clk_i);
            mem_if.data_gnt_i    = 1'b0;
            mem_if.data_rvalid_i = 1'b0;
            mem_if.data_err_i    = 1'b0;
            if (pend) begin
                mem_if.data_rvalid_i = 1'b1;
                mem_if.data_rdata_i  = memw[pend_idx];
                mem_if.data_err_i    = (pend_idx == err_idx);
                pend = 1'b0;
            end else if (spur) begin
                mem_if.data_rvalid_i = 1'b1;
                mem_if.data_rdata_i  = $urandom;
                spur = 1'b0;
            end else if (mem_if.data_req_o && !gnt_block) begin
                cur = int'((mem_if.data_addr_o - BASE) >> 2);
                if (cur > NR) cur = 0;
                if (stall < gdel[cur]) begin
                    stall++;
                end else begin
                    mem_if.data_gnt_i = 1'b1;
                    pend = 1'b1;
                    pend_idx = cur;
                    stall = 0;
                end
            end
        end
    end

    // Output monitor
    initial forever begin
        @(negedge clk_i);
        if (rf_we_o) begin
            wr_idx_q.push_back(int'(rf_waddr_o));
            wr_dat_q.push_back(rf_wdata_o);
        end
        if (pc_valid_o) begin
            pc_cnt++;
            pc_seen = pc_o;
            pc_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_if.data_req_o) begin
            int a;
            a = int'((mem_if.data_addr_o - BASE) >> 2);
            if (a <= NR) req_cnt[a]++;
        end
    end

    task automatic clear_logs();
        wr_idx_q.delete();
        wr_dat_q.delete();
        pc_cnt = 0; done_cnt = 0; pc_cyc = 0; done_cyc = 0; pc_seen = '0;
        for (int i = 0; i <= NR; i++) req_cnt[i] = 0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ctl"}, {mem_if.data_req_o, rf_we_o, pc_valid_o, done_o, busy_o, error_o}, 64'd0);
        check_val({tag, "_addr"}, mem_if.data_addr_o, 64'd0);
        check_val({tag, "_rf"}, {rf_waddr_o, rf_wdata_o}, 64'd0);
        check_val({tag, "_pc"}, pc_o, 64'd0);
    endtask

    task automatic start_seq();
        @(negedge clk_i);
        clear_logs();
        recover_i = 1'b1;
        t_edge = cyc + 1;
    endtask

    task automatic end_seq();
        @(negedge clk_i);
        recover_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && !error_o && n < 600) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 600) check_val({tag, "_bound"}, 64'd1, 64'd0);
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    // Reference model: expected outcome follows directly from the memory image
    task automatic check_seq(input string tag);
        int exp_wr, last, lat, bad;
        bit errd;
        errd   = (err_idx > 0);
        exp_wr = errd ? err_idx - 1 : NR - 1;
        last   = errd ? err_idx : NR;
        lat    = 2 * NR + 1;
        for (int i = 1; i <= NR; i++) lat += gdel[i];
        check_val({tag, "_wr_cnt"}, wr_idx_q.size(), exp_wr);
        for (int i = 0; i < wr_idx_q.size() && i < exp_wr; i++) begin
            check_val({tag, "_waddr"}, wr_idx_q[i], i + 1);
            check_val({tag, "_wdata"}, wr_dat_q[i], memw[i + 1]);
        end
        bad = req_cnt[0];
        for (int i = 1; i <= last; i++) if (req_cnt[i] != gdel[i] + 1) bad++;
        check_val({tag, "_req_hold"}, bad, 64'd0);
        check_val({tag, "_error"}, error_o, errd);
        check_val({tag, "_done_cnt"}, done_cnt, errd ? 0 : 1);
        check_val({tag, "_pc_cnt"}, pc_cnt, errd ? 0 : 1);
        if (!errd) begin
            check_val({tag, "_pc"}, pc_seen, memw[NR]);
            check_val({tag, "_latency"}, done_cyc - t_edge, lat);
            check_val({tag, "_pc_before_done"}, done_cyc - pc_cyc, 64'd1);
            check_val({tag, "_busy"}, busy_o, 64'd0);
        end
    endtask

    initial begin
        int reqc;
        for (int i = 0; i <= NR; i++) begin
            memw[i] = 32'hA000_0000 + 32'(i);
            gdel[i] = 0;
        end
        memw[NR] = 32'h0000_0180;
        clear_logs();

        // Reset state
        repeat (3) @(negedge clk_i);
        check_zero("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Nominal sequence
        start_seq(); wait_end("nominal"); check_seq("nominal"); end_seq();

        // rvalid with nothing outstanding is ignored
        clear_logs();
        spur = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check_val("spur_no_write", wr_idx_q.size(), 64'd0);
        check_val("spur_idle", {busy_o, mem_if.data_req_o}, 64'd0);

        // Grant stalled three cycles on GPR 5
        gdel[5] = 3;
        start_seq(); wait_end("stall"); check_seq("stall");
        check_val("stall_req5_cycles", req_cnt[5], 64'd4);
        end_seq();
        gdel[5] = 0;

        // Read error on GPR 10
        err_idx = 10;
        start_seq(); wait_end("err10"); check_seq("err10");
        repeat (5) @(negedge clk_i);
        #1;
        check_val("err10_sticky", {error_o, done_o, busy_o}, 64'b100);
        end_seq();
        check_val("err10_cleared", {error_o, busy_o}, 64'd0);
        err_idx = 0;

        // recover_i held high: exactly one sequence, then a fresh edge restarts
        start_seq(); wait_end("hold"); check_seq("hold");
        repeat (80) @(negedge clk_i);
        #1;
        check_val("hold_no_restart", {busy_o, 32'(done_cnt), 32'(wr_idx_q.size())}, {1'b0, 32'd1, 32'(NR - 1)});
        end_seq();
        start_seq(); wait_end("rearm"); check_seq("rearm"); end_seq();

        // Reset while waiting for GPR 7's data; the data arrives during reset
        start_seq();
        reqc = 0;
        while (!(mem_if.data_req_o && mem_if.data_addr_o == BASE + 32'd28) && reqc < 200) begin
            @(negedge clk_i);
            #1;
            reqc++;
        end
        if (reqc >= 200) check_val("rst_reach_idx7", 64'd1, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        recover_i = 1'b0;
        #1;
        check_zero("midrst");
        check_val("midrst_writes", wr_idx_q.size(), 64'd6);
        repeat (2) @(negedge clk_i);
        #1;
        check_val("midrst_late_rvalid", {32'(wr_idx_q.size()), rf_we_o, busy_o}, {32'd6, 2'b00});
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        start_seq(); wait_end("post_rst"); check_seq("post_rst"); end_seq();

        // Randomised sequences: random image, random stalls, occasional errors
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i <= NR; i++) begin
                memw[i] = $urandom;
                gdel[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            err_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NR) : 0;
            start_seq(); wait_end("rand"); check_seq("rand"); end_seq();
        end
        err_idx = 0;
        for (int i = 0; i <= NR; i++) gdel[i] = 0;

        // Grant never arrives
        gnt_block = 1'b1;
        start_seq();
        reqc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            #1;
            if (error_o) break;
            if (mem_if.data_req_o) reqc++;
        end
`ifdef FT_LOADER_TIMEOUT_EN
        check_val("tmo_req_cycles", reqc, TMO);
        check_val("tmo_state", {error_o, mem_if.data_req_o, done_o}, 64'b100);
        end_seq();
        check_val("tmo_cleared", error_o, 64'd0);
`else
        check_val("no_tmo_req_cycles", reqc, 64'd40);
        check_val("no_tmo_state", {error_o, mem_if.data_req_o, busy_o}, 64'b011);
`endif
        @(negedge clk_i);
        rst_ni = 1'b0;
        recover_i = 1'b0;
        gnt_block = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
